break_step_controller: RTL and testbench
========================================

// Module: break_step_controller
// PURPOSE
//  Run/halt/single-step sequencer for the core clock. Holds NUM_BP programmable PC breakpoints plus
//  control/status registers on the IO bus. Drives oCoreEn, the clock-enable the core clock divider
//  uses to freeze the core before the instruction at a hit PC executes. Runs on free-running iCLK_50.
// PARAMETERS
//  NUM_BP        4               number of PC breakpoint registers (1..7)
//  BASE_ADDR     32'hFF20_0300   IO base; CTRL @+0x0, BP_i @+0x4*(i+1), HITCNT @+0x20
//  DEBOUNCE_CYC  16              stable cycles required on a key before an event is accepted
//  START_HALTED  0               1: reset state is HALTED instead of RUN
// PORTS
//  iCLK_50       in   1   free-running clock; all state on posedge
//  Reset         in   1   reset, asynchronous, active-high
//  iKEY          in   2   board keys, active-low, async: [0]=step/halt, [1]=resume
//  iPC           in   32  PC of the next instruction to execute, stable while halted
//  iFetch        in   1   1-cycle pulse: new iPC valid, its instruction not yet executed
//  iEbreak       in   1   qualified by iFetch: instruction at iPC is EBREAK
//  wReadEnable   in   1   IO read strobe
//  wWriteEnable  in   1   IO write strobe
//  wByteEnable   in   4   IO byte lanes
//  wAddress      in   32  IO address
//  wWriteData    in   32  IO write data
//  wReadData     out  32  IO read data; 32'bz when not addressed
//  oCoreEn       out  1   core clock enable
//  oHalted       out  1   state==HALTED
//  oCause        out  2   last halt cause: 0 request, 1 breakpoint, 2 ebreak, 3 step
// BEHAVIOUR
//  Reset: state RUN (HALTED if START_HALTED); all BP_i=0, CTRL=0, HITCNT=0, oCause=0,
//   oHalted=START_HALTED, oCoreEn=!START_HALTED, wReadData=z. Reset mid-halt releases the core at once.
//  Registers: CTRL[0] global BP enable RW; CTRL[1] halt request W1, self-clearing, reads 0;
//   CTRL[2] halted RO; CTRL[5:4] cause RO. BP_i[31:2] word address, BP_i[0] enable, BP_i[1] reads 0.
//   HITCNT RO: counts entries to HALTED, saturates at 32'hFFFF_FFFF, any write clears it.
//   Writes honour wByteEnable and land on the next posedge. Reads are combinational.
//  bp_hit = iFetch & CTRL[0] & OR_i(BP_i[0] & iPC[31:2]==BP_i[31:2]); a hit compares against
//   register values before any same-cycle write.
//  Keys: 2-FF sync, then DEBOUNCE_CYC-cycle debounce in key_debounce. One 1-cycle event on each
//   debounced press (high->low). No repeat while the key is held.
//  FSM states RUN, HALTED, STEP:
//   RUN: oCoreEn=1. If iFetch & iEbreak, or bp_hit, or halt request (CTRL[1] write or key0 event),
//    go to HALTED. oCoreEn drops combinationally in that same cycle, so the fetched instruction is
//    not clocked. Priority for oCause: ebreak(2) > breakpoint(1) > request(0). key1 is ignored.
//   HALTED: oCoreEn=0. key0 event -> STEP. key1 event -> RUN. Both in the same cycle -> STEP.
//    Halt requests are ignored. iFetch cannot occur here; if it does, it is ignored.
//   STEP: oCoreEn=1 so the held instruction executes. The next iFetch -> HALTED with oCause=3,
//    oCoreEn low in that cycle. Ebreak and bp_hit on that fetch are not separate causes.
//  Leaving HALTED never re-checks the held PC, so resume from a breakpoint or EBREAK makes progress.
//  oCause and HITCNT update on the posedge that enters HALTED.
// STRUCTURE
//  break_pkg: state_t {RUN,HALTED,STEP}, cause_t {CAUSE_REQ,CAUSE_BP,CAUSE_EBREAK,CAUSE_STEP},
//   register offset localparams.
//  Sub-module key_debounce (sync + DEBOUNCE_CYC counter + press-edge pulse), instantiated 2x.
//  Breakpoint comparators are a generate loop.
// TESTING
//  1 Write BP0=0x0040_0011, CTRL=1; iFetch with iPC=0x0040_0010 -> oCoreEn=0 that cycle,
//    oHalted=1 next cycle, oCause=1, HITCNT=1.
//  2 While halted, key0 press held 20 cycles -> STEP. Next iFetch (iPC=0x0040_0014) -> HALTED,
//    oCause=3, exactly one instruction enabled.
//  3 iFetch with iEbreak=1 and BP hit in the same cycle -> HALTED, oCause=2. key1 -> RUN; the
//    same PC is not re-halted.
//  4 Key0 bouncing (pulses shorter than 16 cycles) while halted -> no transition. Stable press ->
//    exactly one STEP.
//  5 Write CTRL=0x2 in RUN -> HALTED, oCause=0, CTRL reads 0x4. Read 0xFF20_0400 -> wReadData=z.
//  6 Assert Reset while HALTED -> oCoreEn=1 immediately, BP/CTRL/HITCNT=0. With CTRL[0]=0 a
//    matching PC does not halt.

Source files
------------

// File: rtl/break_pkg.sv
// Shared types and register map for the run/halt/single-step controller.
// Offsets are relative to the controller's IO base address.
package break_pkg;

    typedef enum logic [1:0] {RUN, HALTED, STEP} state_t;

    typedef enum logic [1:0] {
        CAUSE_REQ,
        CAUSE_BP,
        CAUSE_EBREAK,
        CAUSE_STEP
    } cause_t;

    localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;
    localparam logic [31:0] BP_STRIDE  = 32'h0000_0004;
    localparam logic [31:0] HITCNT_OFF = 32'h0000_0020;

    function automatic logic [31:0] merge_be(input logic [31:0] cur, input logic [31:0] wdata,
                                             input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? wdata[8*b +: 8] : cur[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key input: 2-FF synchroniser, stability counter, and a one-cycle
// pulse on each accepted press (debounced high->low transition).
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          settle;

    // The counter only runs while the synced level disagrees with the accepted level,
    // so any glitch back to the accepted level restarts the qualification window.
    assign differ = sync_q[1] != stable_q;
    assign settle = differ && (cnt_q == CW'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            press_q <= settle && !sync_q[1];
            if (settle) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
            end else if (differ) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/break_step_controller.sv
// Run/halt/single-step sequencer: PC breakpoints, EBREAK and key/IO halt requests
// gate the core clock enable before the fetched instruction executes.
module break_step_controller
    import break_pkg::*;
#(
    parameter int unsigned NUM_BP       = 4,
    parameter logic [31:0] BASE_ADDR    = 32'hFF20_0300,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter bit          START_HALTED = 1'b0
) (
    input  logic        iCLK_50,
    input  logic        Reset,
    input  logic [1:0]  iKEY,
    input  logic [31:0] iPC,
    input  logic        iFetch,
    input  logic        iEbreak,
    input  logic        wReadEnable,
    input  logic        wWriteEnable,
    input  logic [3:0]  wByteEnable,
    input  logic [31:0] wAddress,
    input  logic [31:0] wWriteData,
    output logic [31:0] wReadData,
    output logic        oCoreEn,
    output logic        oHalted,
    output logic [1:0]  oCause
);

    localparam state_t RESET_STATE = START_HALTED ? HALTED : RUN;

    state_t            state_q, state_d;
    cause_t            cause_q, cause_d;
    logic              ctrl_en_q;
    logic [31:0]       hitcnt_q;
    logic [31:0]       bp_q [NUM_BP];
    logic [NUM_BP-1:0] bp_sel, bp_match;
    logic              ctrl_sel, hit_sel, addr_hit, halt_req, bp_hit, enter_halt;
    logic              key0_press, key1_press;
    logic [31:0]       rdata;
    logic              unused_pc;

    assign unused_pc = ^iPC[1:0];

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key0 (
        .clk   (iCLK_50),
        .rst   (Reset),
        .key_n (iKEY[0]),
        .press (key0_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1 (
        .clk   (iCLK_50),
        .rst   (Reset),
        .key_n (iKEY[1]),
        .press (key1_press)
    );

    assign ctrl_sel = wAddress == BASE_ADDR + CTRL_OFF;
    assign hit_sel  = wAddress == BASE_ADDR + HITCNT_OFF;

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        assign bp_sel[i]   = wAddress == BASE_ADDR + BP_STRIDE * 32'(i + 1);
        assign bp_match[i] = bp_q[i][0] && (iPC[31:2] == bp_q[i][31:2]);
    end

    assign bp_hit   = iFetch && ctrl_en_q && (|bp_match);
    assign halt_req = (wWriteEnable && ctrl_sel && wByteEnable[0] && wWriteData[1]) || key0_press;

    always_ff @(posedge iCLK_50 or posedge Reset) begin
        if (Reset) begin
            ctrl_en_q <= 1'b0;
            for (int i = 0; i < NUM_BP; i++) bp_q[i] <= '0;
        end else if (wWriteEnable) begin
            if (ctrl_sel && wByteEnable[0]) ctrl_en_q <= wWriteData[0];
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_sel[i]) bp_q[i] <= merge_be(bp_q[i], wWriteData, wByteEnable) & ~32'h2;
            end
        end
    end

    assign enter_halt = (state_q != HALTED) && (state_d == HALTED);

    always_ff @(posedge iCLK_50 or posedge Reset) begin
        if (Reset) begin
            hitcnt_q <= '0;
        end else if (wWriteEnable && hit_sel) begin
            hitcnt_q <= '0;
        end else if (enter_halt && (hitcnt_q != 32'hFFFF_FFFF)) begin
            hitcnt_q <= hitcnt_q + 32'd1;
        end
    end

    always_ff @(posedge iCLK_50 or posedge Reset) begin
        if (Reset) begin
            state_q <= RESET_STATE;
            cause_q <= CAUSE_REQ;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Leaving HALTED deliberately skips the PC check so the held instruction can retire.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            RUN: begin
                if (iFetch && iEbreak) begin
                    state_d = HALTED;
                    cause_d = CAUSE_EBREAK;
                end else if (bp_hit) begin
                    state_d = HALTED;
                    cause_d = CAUSE_BP;
                end else if (halt_req) begin
                    state_d = HALTED;
                    cause_d = CAUSE_REQ;
                end
            end
            HALTED: begin
                if (key0_press)      state_d = STEP;
                else if (key1_press) state_d = RUN;
            end
            STEP: begin
                if (iFetch) begin
                    state_d = HALTED;
                    cause_d = CAUSE_STEP;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_comb begin
        oHalted = state_q == HALTED;
        oCoreEn = (state_q != HALTED) && (state_d != HALTED);
        oCause  = cause_q;
    end

    always_comb begin
        addr_hit = ctrl_sel || hit_sel || (|bp_sel);
        rdata    = '0;
        if (ctrl_sel) rdata = {26'b0, cause_q, 1'b0, state_q == HALTED, 1'b0, ctrl_en_q};
        if (hit_sel)  rdata = hitcnt_q;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_sel[i]) rdata = bp_q[i];
        end
    end

    assign wReadData = (wReadEnable && addr_hit) ? rdata : 32'bz;

endmodule

// File: tb/tb_break_step_controller.sv
// Directed bench for break_step_controller: expectations queued as stimulus is
// driven, then popped and checked against DUT outputs.
module tb_break_step_controller;

    localparam logic [31:0] BASE = 32'hFF20_0300;

    logic        iCLK_50 = 1'b0;
    logic        Reset;
    logic [1:0]  iKEY;
    logic [31:0] iPC;
    logic        iFetch, iEbreak, wReadEnable, wWriteEnable;
    logic [3:0]  wByteEnable;
    logic [31:0] wAddress, wWriteData;
    wire  [31:0] wReadData;
    logic        oCoreEn, oHalted;
    logic [1:0]  oCause;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    break_step_controller dut (
        .iCLK_50      (iCLK_50),
        .Reset        (Reset),
        .iKEY         (iKEY),
        .iPC          (iPC),
        .iFetch       (iFetch),
        .iEbreak      (iEbreak),
        .wReadEnable  (wReadEnable),
        .wWriteEnable (wWriteEnable),
        .wByteEnable  (wByteEnable),
        .wAddress     (wAddress),
        .wWriteData   (wWriteData),
        .wReadData    (wReadData),
        .oCoreEn      (oCoreEn),
        .oHalted      (oHalted),
        .oCause       (oCause)
    );

    always #10 iCLK_50 = ~iCLK_50;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic observe(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h required queued entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge iCLK_50);
    endtask

    task automatic io_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wAddress     = a;
        wWriteData   = d;
        wByteEnable  = be;
        wWriteEnable = 1'b1;
        cyc(1);
        wWriteEnable = 1'b0;
        wByteEnable  = 4'h0;
    endtask

    task automatic io_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        expect_val(tag, exp);
        wAddress    = a;
        wReadEnable = 1'b1;
        #1;
        observe(wReadData);
        wReadEnable = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] pc, input logic eb,
                         input logic exp_en);
        expect_val(tag, {31'b0, exp_en});
        iPC     = pc;
        iEbreak = eb;
        iFetch  = 1'b1;
        #1;
        observe({31'b0, oCoreEn});
        cyc(1);
        iFetch  = 1'b0;
        iEbreak = 1'b0;
    endtask

    task automatic status(input string tag, input logic h, input logic [1:0] c);
        expect_val({tag, "_halted"}, {31'b0, h});
        expect_val({tag, "_cause"}, {30'b0, c});
        observe({31'b0, oHalted});
        observe({30'b0, oCause});
    endtask

    // Holds a key low for 20 cycles, releases it, and counts oHalted changes meanwhile.
    task automatic key_press(input int idx, output int changes);
        logic prev;
        prev    = oHalted;
        changes = 0;
        iKEY[idx] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (oHalted !== prev) begin changes++; prev = oHalted; end
        end
        iKEY[idx] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cyc(1);
            if (oHalted !== prev) begin changes++; prev = oHalted; end
        end
    endtask

    initial begin
        int   ch;
        int   en_cnt;
        logic zok;

        Reset = 1'b1; iKEY = 2'b11; iPC = '0; iFetch = 1'b0; iEbreak = 1'b0;
        wReadEnable = 1'b0; wWriteEnable = 1'b0; wByteEnable = '0; wAddress = '0; wWriteData = '0;
        #5;
        expect_val("rst_core_en", 32'd1); observe({31'b0, oCoreEn});
        status("rst", 1'b0, 2'd0);
        zok = (wReadData === 32'bz);
        expect_val("rst_rdata_z", 32'd1); observe({31'b0, zok});
        cyc(2);
        Reset = 1'b0;
        cyc(1);
        io_rd("rst_ctrl", BASE, 32'h0);
        io_rd("rst_hitcnt", BASE + 32'h20, 32'h0);

        // Breakpoint hit
        io_wr(BASE + 32'h4, 32'h0040_0011, 4'hF);
        io_wr(BASE + 32'hC, 32'h1234_5678, 4'b0101);
        io_wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
        io_wr(BASE, 32'h1, 4'h1);
        io_rd("bp0_rd", BASE + 32'h4, 32'h0040_0011);
        io_rd("bp2_byte_en", BASE + 32'hC, 32'h0034_0078);
        io_rd("bp1_bit1_zero", BASE + 32'h8, 32'hFFFF_FFFD);
        fetch("bp_core_en", 32'h0040_0010, 1'b0, 1'b0);
        status("bp_halt", 1'b1, 2'd1);
        io_rd("bp_hitcnt", BASE + 32'h20, 32'd1);
        io_rd("bp_ctrl", BASE, 32'h15);

        // Single step via key0
        key_press(0, ch);
        expect_val("step_entered", 32'd1); observe(32'(ch));
        expect_val("step_core_en", 32'd1); observe({31'b0, oCoreEn});
        fetch("step_fetch_en", 32'h0040_0014, 1'b0, 1'b0);
        status("step_halt", 1'b1, 2'd3);
        io_rd("step_hitcnt", BASE + 32'h20, 32'd2);
        en_cnt = 0;
        for (int i = 0; i < 5; i++) begin cyc(1); if (oCoreEn) en_cnt++; end
        expect_val("step_held_en_cycles", 32'd0); observe(32'(en_cnt));

        // EBREAK beats breakpoint; resume does not re-halt
        key_press(1, ch);
        expect_val("resume_run", 32'd1); observe(32'(ch));
        fetch("ebreak_core_en", 32'h0040_0010, 1'b1, 1'b0);
        status("ebreak_halt", 1'b1, 2'd2);
        key_press(1, ch);
        expect_val("ebreak_resume", 32'd1); observe(32'(ch));
        expect_val("resume_core_en", 32'd1); observe({31'b0, oCoreEn});
        fetch("no_rehalt_en", 32'h0040_0014, 1'b0, 1'b1);
        cyc(2);
        status("no_rehalt", 1'b0, 2'd2);
        key_press(1, ch);
        expect_val("key1_ignored_in_run", 32'd0); observe(32'(ch));

        // Key0 halt request, then bounce rejection
        key_press(0, ch);
        expect_val("key0_halt", 32'd1); observe(32'(ch));
        status("key0_halt", 1'b1, 2'd0);
        ch = 0;
        for (int p = 0; p < 4; p++) begin
            iKEY[0] = 1'b0;
            for (int i = 0; i < 5; i++) begin cyc(1); if (!oHalted) ch++; end
            iKEY[0] = 1'b1;
            for (int i = 0; i < 5; i++) begin cyc(1); if (!oHalted) ch++; end
        end
        for (int i = 0; i < 20; i++) begin cyc(1); if (!oHalted) ch++; end
        expect_val("bounce_no_step", 32'd0); observe(32'(ch));
        key_press(0, ch);
        expect_val("stable_one_step", 32'd1); observe(32'(ch));
        fetch("step2_fetch_en", 32'h0040_0018, 1'b0, 1'b0);
        status("step2_halt", 1'b1, 2'd3);
        io_rd("step2_hitcnt", BASE + 32'h20, 32'd5);
        io_wr(BASE + 32'h20, 32'h0, 4'h0);
        io_rd("hitcnt_clear", BASE + 32'h20, 32'd0);
        key_press(1, ch);
        expect_val("run_before_ctrl", 32'd1); observe(32'(ch));

        // CTRL halt request and unmapped read
        expect_val("ctrl_req_core_en", 32'd0);
        wAddress = BASE; wWriteData = 32'h2; wByteEnable = 4'h1; wWriteEnable = 1'b1;
        #1;
        observe({31'b0, oCoreEn});
        cyc(1);
        wWriteEnable = 1'b0; wByteEnable = 4'h0;
        status("ctrl_req", 1'b1, 2'd0);
        io_rd("ctrl_read_halted", BASE, 32'h4);
        io_rd("ctrl_hitcnt", BASE + 32'h20, 32'd1);
        wAddress = 32'hFF20_0400; wReadEnable = 1'b1;
        #1;
        zok = (wReadData === 32'bz);
        expect_val("unmapped_rdata_z", 32'd1); observe({31'b0, zok});
        wReadEnable = 1'b0;

        // Reset while halted
        cyc(1);
        Reset = 1'b1;
        #1;
        expect_val("midreset_core_en", 32'd1); observe({31'b0, oCoreEn});
        expect_val("midreset_halted", 32'd0); observe({31'b0, oHalted});
        cyc(1);
        Reset = 1'b0;
        cyc(1);
        io_rd("post_rst_bp0", BASE + 32'h4, 32'h0);
        io_rd("post_rst_ctrl", BASE, 32'h0);
        io_rd("post_rst_hitcnt", BASE + 32'h20, 32'h0);
        io_wr(BASE + 32'h4, 32'h0040_0011, 4'hF);
        fetch("bp_disabled_en", 32'h0040_0010, 1'b0, 1'b1);
        status("bp_disabled", 1'b0, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
